execute_stage: RTL and testbench

Execute stage of the 24-bit pipeline; consumer of the 123-bit ID/EX bundle produced by instruction decode. Unpacks the bundle, resolves operands with MEM/WB forwarding, performs the ALU operation, and runs multiply as an iterative 24-cycle operation. Registers results into an EX/MEM output slot under a valid/ready handshake. Raises `stall` so decode holds its ID/EX buffer while the stage is busy or the output is blocked.

---
 rtl/pipeline_pkg.sv | 98 +++++++++
 rtl/iterative_multiplier.sv | 64 ++++++
 rtl/execute_stage.sv | 201 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the 24-bit pipeline.
//   - ID/EX bundle field positions and widths
//   - ALU operation encoding, opType constants
//   - EX-stage FSM state, MUL control latch and EX/MEM slot layouts
//   - fwd_sel(): MEM/WB operand forwarding mux
package pipeline_pkg;

  localparam int unsigned DataW        = 24;
  localparam int unsigned RegW         = 4;
  localparam int unsigned BundleW      = 123;
  localparam int unsigned DefMulCycles = 24;

  // ID/EX bundle field LSB positions
  localparam int unsigned OpTypeLsb   = 121;
  localparam int unsigned OpTypeW     = 2;
  localparam int unsigned OpCodeLsb   = 117;
  localparam int unsigned OpCodeW     = 4;
  localparam int unsigned ImmSrcBit   = 116;
  localparam int unsigned BranchBit   = 115;
  localparam int unsigned MemWriteBit = 114;
  localparam int unsigned MemToRegBit = 113;
  localparam int unsigned RegWriteBit = 112;
  localparam int unsigned AluLsb      = 108;
  localparam int unsigned AluW        = 4;
  localparam int unsigned RaLsb       = 104;
  localparam int unsigned Rd1Lsb      = 80;
  localparam int unsigned RbLsb       = 76;
  localparam int unsigned Rd2Lsb      = 52;
  localparam int unsigned RcLsb       = 48;
  localparam int unsigned Rd3Lsb      = 24;
  localparam int unsigned ImmLsb      = 0;

  localparam logic [OpTypeW-1:0] OpTypeAlu    = 2'd0;
  localparam logic [OpTypeW-1:0] OpTypeMem    = 2'd1;
  localparam logic [OpTypeW-1:0] OpTypeBranch = 2'd2;
  localparam logic [OpTypeW-1:0] OpTypeSys    = 2'd3;

  typedef enum logic [AluW-1:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluSll = 4'd5,
    AluSrl = 4'd6,
    AluSra = 4'd7,
    AluMul = 4'd8,
    AluMov = 4'd9
  } alu_op_e;

  typedef enum logic [0:0] {
    StIdle,
    StMult
  } ex_state_e;

  // Control carried alongside a MUL while it iterates
  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
    logic             branch;
    logic [RegW-1:0]  rd;
    logic [DataW-1:0] store;
  } ex_ctrl_t;

  // EX/MEM output slot contents
  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
    logic [RegW-1:0]  rd;
    logic [DataW-1:0] result;
    logic [DataW-1:0] store;
    logic             zero;
    logic             neg;
    logic             br_taken;
  } ex_slot_t;

  // MEM match has priority over WB match; no register reads as hardwired zero.
  function automatic logic [DataW-1:0] fwd_sel(
    input logic [RegW-1:0]  r,
    input logic [DataW-1:0] d,
    input logic             mem_we,
    input logic [RegW-1:0]  mem_rd,
    input logic [DataW-1:0] mem_data,
    input logic             wb_we,
    input logic [RegW-1:0]  wb_rd,
    input logic [DataW-1:0] wb_data
  );
    if (mem_we && (mem_rd == r)) begin
      return mem_data;
    end else if (wb_we && (wb_rd == r)) begin
      return wb_data;
    end
    return d;
  endfunction

endpackage

// File: rtl/iterative_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
//   start_i  : latch a_i/b_i and begin (restarts any operation in flight)
//   take_i   : consumer has taken the result; drop busy
//   done_o   : result_o is valid this cycle (final step in flight or finished)
//   result_o : low Width bits of a_i * b_i
module iterative_multiplier #(
  parameter int unsigned Width  = 24,
  parameter int unsigned Cycles = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             take_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] result_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);
  localparam logic [CntW-1:0] CntEnd  = CntW'(Cycles);

  logic             busy_q;
  logic [CntW-1:0]  cnt_q;
  logic [Width-1:0] acc_q, mcand_q, mplier_q;
  logic [Width-1:0] acc_step;
  logic             step;

  assign step     = busy_q && (cnt_q != CntEnd);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // The last step's sum is exposed combinationally so the slot can load on the
  // same edge that completes the final iteration; afterwards acc_q is frozen.
  assign done_o   = busy_q && ((cnt_q == CntLast) || (cnt_q == CntEnd));
  assign result_o = (cnt_q == CntEnd) ? acc_q : acc_step;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else begin
      if (step) begin
        acc_q    <= acc_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (take_i && done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: unpacks the ID/EX bundle, forwards operands from MEM/WB,
// runs the ALU (or the iterative multiplier) and registers the result in an
// EX/MEM slot under a valid/ready handshake.
//   idex_bundle_i/idex_valid_i : instruction from decode
//   fwd_mem_* / fwd_wb_*       : writeback candidates for forwarding
//   out_ready_i                : EX/MEM consumer takes the slot
//   stall_o                    : decode must hold its ID/EX buffer
//   out_*_o                    : EX/MEM slot contents; out_rd_o is the Rc field
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned Width     = DataW,
  parameter int unsigned MulCycles = DefMulCycles
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [BundleW-1:0] idex_bundle_i,
  input  logic               idex_valid_i,
  input  logic               fwd_mem_we_i,
  input  logic [RegW-1:0]    fwd_mem_rd_i,
  input  logic [Width-1:0]   fwd_mem_data_i,
  input  logic               fwd_wb_we_i,
  input  logic [RegW-1:0]    fwd_wb_rd_i,
  input  logic [Width-1:0]   fwd_wb_data_i,
  input  logic               out_ready_i,
  output logic               stall_o,
  output logic               out_valid_o,
  output logic               out_reg_write_o,
  output logic               out_mem_write_o,
  output logic               out_mem_to_reg_o,
  output logic [RegW-1:0]    out_rd_o,
  output logic [Width-1:0]   out_result_o,
  output logic [Width-1:0]   out_store_data_o,
  output logic               out_branch_taken_o,
  output logic               out_zero_o,
  output logic               out_neg_o
);

  // Bundle fields
  logic [OpTypeW+OpCodeW-1:0] unused_op_fields;
  logic                       imm_src;
  alu_op_e                    alu_op;
  logic [RegW-1:0]            ra, rb, rc;
  logic [Width-1:0]           rd1, rd2, rd3, imm;

  assign unused_op_fields = {idex_bundle_i[OpTypeLsb +: OpTypeW], idex_bundle_i[OpCodeLsb +: OpCodeW]};
  assign imm_src = idex_bundle_i[ImmSrcBit];
  assign alu_op  = alu_op_e'(idex_bundle_i[AluLsb +: AluW]);
  assign ra      = idex_bundle_i[RaLsb +: RegW];
  assign rb      = idex_bundle_i[RbLsb +: RegW];
  assign rc      = idex_bundle_i[RcLsb +: RegW];
  assign rd1     = idex_bundle_i[Rd1Lsb +: DataW];
  assign rd2     = idex_bundle_i[Rd2Lsb +: DataW];
  assign rd3     = idex_bundle_i[Rd3Lsb +: DataW];
  assign imm     = idex_bundle_i[ImmLsb +: DataW];

  // Operand resolution
  logic [Width-1:0] op1, op2, store_data;

  assign op1 = fwd_sel(ra, rd1, fwd_mem_we_i, fwd_mem_rd_i, fwd_mem_data_i,
                       fwd_wb_we_i, fwd_wb_rd_i, fwd_wb_data_i);
  assign op2 = imm_src ? imm :
               fwd_sel(rb, rd2, fwd_mem_we_i, fwd_mem_rd_i, fwd_mem_data_i,
                       fwd_wb_we_i, fwd_wb_rd_i, fwd_wb_data_i);
  assign store_data = fwd_sel(rc, rd3, fwd_mem_we_i, fwd_mem_rd_i, fwd_mem_data_i,
                              fwd_wb_we_i, fwd_wb_rd_i, fwd_wb_data_i);

  // ALU; shifts use op2[4:0], so amounts >= Width fall out of the native shift
  logic [Width-1:0] alu_res;
  logic             alu_legal;
  logic [4:0]       shamt;

  assign shamt = op2[4:0];

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (alu_op)
      AluAdd:  alu_res = op1 + op2;
      AluSub:  alu_res = op1 - op2;
      AluAnd:  alu_res = op1 & op2;
      AluOr:   alu_res = op1 | op2;
      AluXor:  alu_res = op1 ^ op2;
      AluSll:  alu_res = op1 << shamt;
      AluSrl:  alu_res = op1 >> shamt;
      AluSra:  alu_res = $signed(op1) >>> shamt;
      AluMul:  alu_res = '0;
      AluMov:  alu_res = op2;
      default: alu_legal = 1'b0;
    endcase
  end

  ex_ctrl_t cur_ctrl;

  // Reserved opcodes must not write anything
  assign cur_ctrl = '{
    reg_write:  idex_bundle_i[RegWriteBit] & alu_legal,
    mem_write:  idex_bundle_i[MemWriteBit] & alu_legal,
    mem_to_reg: idex_bundle_i[MemToRegBit] & alu_legal,
    branch:     idex_bundle_i[BranchBit],
    rd:         rc,
    store:      store_data
  };

  // Handshake and FSM
  ex_state_e        state_q, state_d;
  ex_slot_t         slot_q, slot_d;
  logic             out_valid_q, out_valid_d;
  ex_ctrl_t         mul_ctrl_q;
  logic             slot_free, accept, is_mul, mul_start, mul_done, mul_load, alu_load;
  logic [Width-1:0] mul_result;

  assign is_mul    = (alu_op == AluMul);
  assign slot_free = ~out_valid_q | out_ready_i;
  assign accept    = idex_valid_i & (state_q == StIdle) & slot_free;
  assign stall_o   = idex_valid_i & ~accept;
  assign mul_start = accept & is_mul;
  assign alu_load  = accept & ~is_mul;
  assign mul_load  = (state_q == StMult) & mul_done & slot_free;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mul_start) state_d = StMult;
      StMult: if (mul_done && slot_free) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  iterative_multiplier #(
    .Width  (Width),
    .Cycles (MulCycles)
  ) u_mul (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (mul_start),
    .take_i   (mul_load),
    .a_i      (op1),
    .b_i      (op2),
    .done_o   (mul_done),
    .result_o (mul_result)
  );

  // Output slot next state
  ex_ctrl_t         ld_ctrl;
  logic [Width-1:0] ld_res;

  always_comb begin
    ld_ctrl = cur_ctrl;
    ld_res  = alu_res;
    if (state_q == StMult) begin
      ld_ctrl = mul_ctrl_q;
      ld_res  = mul_result;
    end

    slot_d      = slot_q;
    out_valid_d = out_valid_q & ~out_ready_i;
    if (alu_load || mul_load) begin
      out_valid_d = 1'b1;
      slot_d = '{
        reg_write:  ld_ctrl.reg_write,
        mem_write:  ld_ctrl.mem_write,
        mem_to_reg: ld_ctrl.mem_to_reg,
        rd:         ld_ctrl.rd,
        result:     ld_res,
        store:      ld_ctrl.store,
        zero:       (ld_res == '0),
        neg:        ld_res[Width-1],
        br_taken:   ld_ctrl.branch & (ld_res == '0)
      };
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      slot_q      <= '0;
      mul_ctrl_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
      if (mul_start) begin
        mul_ctrl_q <= cur_ctrl;
      end
    end
  end

  assign out_valid_o        = out_valid_q;
  assign out_reg_write_o    = slot_q.reg_write;
  assign out_mem_write_o    = slot_q.mem_write;
  assign out_mem_to_reg_o   = slot_q.mem_to_reg;
  assign out_rd_o           = slot_q.rd;
  assign out_result_o       = slot_q.result;
  assign out_store_data_o   = slot_q.store;
  assign out_branch_taken_o = slot_q.br_taken;
  assign out_zero_o         = slot_q.zero;
  assign out_neg_o          = slot_q.neg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a table of single-cycle ALU vectors
// applied back-to-back, then hand sequences for MUL latency, output
// back-pressure and reset during a multiply.
module tb_execute_stage;

  logic          clk;
  logic          rst_n;
  logic [122:0]  idex_bundle;
  logic          idex_valid;
  logic          fwd_mem_we, fwd_wb_we;
  logic [3:0]    fwd_mem_rd, fwd_wb_rd;
  logic [23:0]   fwd_mem_data, fwd_wb_data;
  logic          out_ready;
  logic          stall, out_valid, out_reg_write, out_mem_write, out_mem_to_reg;
  logic [3:0]    out_rd;
  logic [23:0]   out_result, out_store_data;
  logic          out_branch_taken, out_zero, out_neg;

  execute_stage dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .idex_bundle_i      (idex_bundle),
    .idex_valid_i       (idex_valid),
    .fwd_mem_we_i       (fwd_mem_we),
    .fwd_mem_rd_i       (fwd_mem_rd),
    .fwd_mem_data_i     (fwd_mem_data),
    .fwd_wb_we_i        (fwd_wb_we),
    .fwd_wb_rd_i        (fwd_wb_rd),
    .fwd_wb_data_i      (fwd_wb_data),
    .out_ready_i        (out_ready),
    .stall_o            (stall),
    .out_valid_o        (out_valid),
    .out_reg_write_o    (out_reg_write),
    .out_mem_write_o    (out_mem_write),
    .out_mem_to_reg_o   (out_mem_to_reg),
    .out_rd_o           (out_rd),
    .out_result_o       (out_result),
    .out_store_data_o   (out_store_data),
    .out_branch_taken_o (out_branch_taken),
    .out_zero_o         (out_zero),
    .out_neg_o          (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu;
    logic        imm_src, branch, mem_write, mem_to_reg, reg_write;
    logic [3:0]  ra, rb, rc;
    logic [23:0] rd1, rd2, rd3, imm;
    logic        mem_we, wb_we;
    logic [3:0]  mem_rd, wb_rd;
    logic [23:0] mem_data, wb_data;
    logic [23:0] exp_res, exp_store;
    logic [2:0]  exp_flags;  // {zero, neg, branch_taken}
    logic [2:0]  exp_ctrl;   // {reg_write, mem_write, mem_to_reg}
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] alu, input logic imm_src, input logic br,
                              input logic [23:0] rd1, input logic [23:0] rd2,
                              input logic [23:0] imm, input logic [23:0] exp_res,
                              input logic [2:0] exp_flags);
    vec_t v;
    v.alu = alu; v.imm_src = imm_src; v.branch = br;
    v.reg_write = 1'b1; v.mem_write = 1'b0; v.mem_to_reg = 1'b0;
    v.ra = 4'd1; v.rb = 4'd2; v.rc = 4'd9;
    v.rd1 = rd1; v.rd2 = rd2; v.rd3 = 24'h0000AB; v.imm = imm;
    v.mem_we = 1'b0; v.mem_rd = 4'd0; v.mem_data = 24'd0;
    v.wb_we = 1'b0; v.wb_rd = 4'd0; v.wb_data = 24'd0;
    v.exp_res = exp_res; v.exp_store = 24'h0000AB;
    v.exp_flags = exp_flags; v.exp_ctrl = 3'b100;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    idex_bundle = {2'b00, 4'h0, v.imm_src, v.branch, v.mem_write, v.mem_to_reg, v.reg_write,
                   v.alu, v.ra, v.rd1, v.rb, v.rd2, v.rc, v.rd3, v.imm};
    fwd_mem_we = v.mem_we; fwd_mem_rd = v.mem_rd; fwd_mem_data = v.mem_data;
    fwd_wb_we = v.wb_we; fwd_wb_rd = v.wb_rd; fwd_wb_data = v.wb_data;
    idex_valid = 1'b1;
  endtask

  vec_t vecs[$];
  vec_t t;
  int   bad_stall, bad_early, bad_valid;

  initial begin
    rst_n = 1'b0; idex_valid = 1'b0; out_ready = 1'b1; idex_bundle = '0;
    fwd_mem_we = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    fwd_wb_we = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;

    // ---- vector table ----
    vecs.push_back(mk(4'd0, 0, 0, 24'd5, 24'd7, 24'd0, 24'd12, 3'b000));          // ADD
    vecs.push_back(mk(4'd1, 0, 1, 24'd3, 24'd3, 24'd0, 24'd0, 3'b101));           // SUB to 0, branch
    vecs.push_back(mk(4'd1, 0, 0, 24'd2, 24'd3, 24'd0, 24'hFFFFFF, 3'b010));      // SUB negative
    t = mk(4'd0, 1, 0, 24'd1, 24'd0, 24'd1, 24'h11, 3'b000);                      // MEM beats WB
    t.ra = 4'd4; t.mem_we = 1; t.mem_rd = 4'd4; t.mem_data = 24'h10;
    t.wb_we = 1; t.wb_rd = 4'd4; t.wb_data = 24'h20;
    vecs.push_back(t);
    t.mem_we = 0; t.exp_res = 24'h21;                                             // WB only
    vecs.push_back(t);
    vecs.push_back(mk(4'd2, 0, 0, 24'hF0F0F0, 24'h0FF0FF, 24'd0, 24'h00F0F0, 3'b000));
    vecs.push_back(mk(4'd3, 0, 0, 24'h0F0000, 24'h0000F0, 24'd0, 24'h0F00F0, 3'b000));
    vecs.push_back(mk(4'd4, 0, 0, 24'hFFFFFF, 24'h0F0F0F, 24'd0, 24'hF0F0F0, 3'b010));
    vecs.push_back(mk(4'd5, 1, 0, 24'd1, 24'd0, 24'd23, 24'h800000, 3'b010));     // SLL 23
    vecs.push_back(mk(4'd5, 1, 1, 24'd1, 24'd0, 24'd24, 24'h000000, 3'b101));     // SLL 24
    vecs.push_back(mk(4'd5, 1, 0, 24'd3, 24'd0, 24'h21, 24'd6, 3'b000));          // only op2[4:0]
    vecs.push_back(mk(4'd6, 1, 0, 24'h800000, 24'd0, 24'd4, 24'h080000, 3'b000));
    vecs.push_back(mk(4'd7, 1, 0, 24'h800000, 24'd0, 24'd4, 24'hF80000, 3'b010));
    vecs.push_back(mk(4'd7, 1, 0, 24'h800000, 24'd0, 24'h3F, 24'hFFFFFF, 3'b010)); // SRA 31
    vecs.push_back(mk(4'd9, 1, 0, 24'd5, 24'd0, 24'h123456, 24'h123456, 3'b000)); // MOV imm
    t = mk(4'd9, 0, 0, 24'd0, 24'h111111, 24'd0, 24'h222222, 3'b000);            // MOV fwd Rb
    t.rb = 4'd6; t.wb_we = 1; t.wb_rd = 4'd6; t.wb_data = 24'h222222;
    t.mem_we = 1; t.mem_rd = 4'd7; t.mem_data = 24'h333333;
    vecs.push_back(t);
    t = mk(4'd12, 0, 0, 24'd5, 24'd7, 24'd0, 24'd0, 3'b100);                     // reserved
    t.mem_write = 1; t.mem_to_reg = 1; t.exp_ctrl = 3'b000;
    vecs.push_back(t);
    vecs.push_back(mk(4'd0, 0, 0, 24'hFFFFFF, 24'd2, 24'd0, 24'd1, 3'b000));      // wrap
    t = mk(4'd0, 0, 0, 24'd1, 24'd1, 24'd0, 24'd2, 3'b000);                       // store fwd
    t.rc = 4'd5; t.rd3 = 24'hAAA; t.mem_we = 1; t.mem_rd = 4'd5; t.mem_data = 24'hBBB;
    t.wb_we = 1; t.wb_rd = 4'd5; t.wb_data = 24'hCCC; t.exp_store = 24'hBBB;
    t.reg_write = 0; t.mem_write = 1; t.exp_ctrl = 3'b010;
    vecs.push_back(t);
    t = mk(4'd0, 0, 0, 24'd4, 24'd4, 24'd0, 24'd8, 3'b000);
    t.mem_to_reg = 1; t.exp_ctrl = 3'b101;
    vecs.push_back(t);

    // ---- reset state ----
    #2;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset outputs", {out_result, out_rd, out_reg_write, out_mem_write, out_mem_to_reg,
                          out_branch_taken, out_zero, out_neg}, 0);
    chk("reset store", 32'(out_store_data), 0);
    idex_valid = 1'b1;
    #1 chk("reset stall with valid", 32'(stall), 0);
    idex_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // ---- table, back-to-back ----
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 chk($sformatf("vec%0d stall", i), 32'(stall), 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d result", i), 32'(out_result), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d store", i), 32'(out_store_data), 32'(vecs[i].exp_store));
      chk($sformatf("vec%0d flags", i), {out_zero, out_neg, out_branch_taken},
          32'(vecs[i].exp_flags));
      chk($sformatf("vec%0d ctrl/rd", i), {out_reg_write, out_mem_write, out_mem_to_reg, out_rd},
          {vecs[i].exp_ctrl, vecs[i].rc});
    end

    // ---- MUL: 0x123 * 0x456, waiting ADD behind it ----
    @(negedge clk);
    t = mk(4'd8, 0, 0, 24'h000123, 24'h000456, 24'd0, 24'd0, 3'b000); t.rc = 4'd3;
    drive(t);
    #1 chk("mul accept stall", 32'(stall), 0);
    @(posedge clk);
    bad_stall = 0; bad_early = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) begin
        t = mk(4'd0, 0, 0, 24'd5, 24'd7, 24'd0, 24'd0, 3'b000); t.rc = 4'd4;
        drive(t);
      end
      #1;
      if (stall !== 1'b1) bad_stall++;
      if (out_valid !== 1'b0) bad_early++;
      @(posedge clk);
    end
    #1;
    chk("mul stall held", 32'(bad_stall), 0);
    chk("mul no early result", 32'(bad_early), 0);
    chk("mul out_valid", 32'(out_valid), 1);
    chk("mul result", 32'(out_result), 32'h04EDC2);
    chk("mul rd/regwrite", {out_rd, out_reg_write}, {4'd3, 1'b1});
    chk("mul flags", {out_zero, out_neg}, 0);
    @(negedge clk); #1 chk("post-mul stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("post-mul add result", 32'(out_result), 12);
    chk("post-mul add rd", 32'(out_rd), 4);

    // ---- back-pressure ----
    @(negedge clk); idex_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); out_ready = 1'b0;
    t = mk(4'd0, 0, 0, 24'd1, 24'd1, 24'd0, 24'd0, 3'b000); t.rc = 4'd1; drive(t);
    #1 chk("bp first stall", 32'(stall), 0);
    @(posedge clk);
    @(negedge clk);
    t = mk(4'd0, 0, 0, 24'd3, 24'd4, 24'd0, 24'd0, 3'b000); t.rc = 4'd2; drive(t);
    #1 chk("bp blocked stall", 32'(stall), 1);
    @(posedge clk); #1;
    chk("bp hold valid", 32'(out_valid), 1);
    chk("bp hold result", {out_result, out_rd}, {24'd2, 4'd1});
    @(negedge clk); out_ready = 1'b1;
    #1 chk("bp release stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("bp reload valid", 32'(out_valid), 1);
    chk("bp reload result", {out_result, out_rd}, {24'd7, 4'd2});
    @(negedge clk); idex_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp pop clears valid", 32'(out_valid), 0);
    chk("bp result kept", 32'(out_result), 7);

    // ---- reset during MUL ----
    @(negedge clk);
    t = mk(4'd8, 0, 0, 24'd3, 24'd5, 24'd0, 24'd0, 3'b000); drive(t);
    @(posedge clk);
    @(negedge clk); idex_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    t = mk(4'd0, 0, 0, 24'd1, 24'd1, 24'd0, 24'd0, 3'b000); drive(t);
    #1;
    chk("midmul reset valid", 32'(out_valid), 0);
    chk("midmul reset result", 32'(out_result), 0);
    chk("midmul reset idle stall", 32'(stall), 0);
    @(negedge clk); idex_valid = 1'b0; rst_n = 1'b1;
    bad_valid = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad_valid++;
    end
    chk("abandoned mul never emits", 32'(bad_valid), 0);
    @(negedge clk);
    t = mk(4'd0, 0, 0, 24'd2, 24'd2, 24'd0, 24'd0, 3'b000); t.rc = 4'd6; drive(t);
    #1 chk("after reset stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("after reset valid", 32'(out_valid), 1);
    chk("after reset result", {out_result, out_rd}, {24'd4, 4'd6});
    @(negedge clk); idex_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
